// File: rtl/csr_counter_reader.sv
// csr_counter_reader: reads/writes the 64-bit CSR performance counters
// (cycle, time, instret) over a 32-bit CSR port.
// Reads use a high/low/high sequence with bounded retry so the returned
// value is never torn. Writes go out as two half-word CSR writes.
// Ports:
//   clk, reset (async, active-low)
//   req_*  : core request (valid/ready, write flag, counter select, write data)
//   resp_* : response (valid/ready, data, error, retry count)
//   csr_*  : CSR command/address/write-data out, combinational read data in
module csr_counter_reader #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CSR_CMD_LEN  = 2,
    parameter int unsigned CSR_ADDR_LEN = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_sel,
    input  logic [2*XLEN-1:0]       req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [2*XLEN-1:0]       resp_data,
    output logic                    resp_error,
    output logic [1:0]              resp_retries,
    output logic [CSR_CMD_LEN-1:0]  csr_cmd,
    output logic [CSR_ADDR_LEN-1:0] csr_addr,
    output logic [XLEN-1:0]         csr_wdata,
    input  logic [XLEN-1:0]         csr_rdata
);

    localparam int unsigned CW      = 2 * XLEN;
    localparam int unsigned RETRY_W = 2;
    localparam int unsigned SEL_W   = 2;

    localparam logic [CSR_CMD_LEN-1:0]  CSR_READ     = CSR_CMD_LEN'(0);
    localparam logic [CSR_CMD_LEN-1:0]  CSR_WRITE    = CSR_CMD_LEN'(1);
    localparam logic [CSR_ADDR_LEN-1:0] ADDR_LO_BASE = CSR_ADDR_LEN'(12'hC00);
    localparam logic [CSR_ADDR_LEN-1:0] ADDR_HI_BASE = CSR_ADDR_LEN'(12'hC80);
    localparam logic [SEL_W-1:0]        SEL_INVALID  = SEL_W'(3);
    localparam logic [RETRY_W-1:0]      RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO, WR_HI, RESP
    } state_t;

    // Low/high CSR address for a counter select (CYCLE/TIME/INSTRET and their H halves)
    function automatic logic [CSR_ADDR_LEN-1:0] lo_addr(input logic [SEL_W-1:0] s);
        return ADDR_LO_BASE + CSR_ADDR_LEN'(s);
    endfunction

    function automatic logic [CSR_ADDR_LEN-1:0] hi_addr(input logic [SEL_W-1:0] s);
        return ADDR_HI_BASE + CSR_ADDR_LEN'(s);
    endfunction

    state_t                    state, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [CW-1:0]             wdata_q, wdata_d;
    logic [XLEN-1:0]           hi1_q, hi1_d;
    logic [XLEN-1:0]           lo_q, lo_d;
    logic [RETRY_W-1:0]        retries_q, retries_d;

    logic                      req_ready_d;
    logic                      resp_valid_d;
    logic [CW-1:0]             resp_data_d;
    logic                      resp_error_d;
    logic [1:0]                resp_retries_d;
    logic [CSR_CMD_LEN-1:0]    csr_cmd_d;
    logic [CSR_ADDR_LEN-1:0]   csr_addr_d;
    logic [XLEN-1:0]           csr_wdata_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sel_q        <= '0;
            wdata_q      <= '0;
            hi1_q        <= '0;
            lo_q         <= '0;
            retries_q    <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_error   <= 1'b0;
            resp_retries <= '0;
            csr_cmd      <= CSR_READ;
            csr_addr     <= '0;
            csr_wdata    <= '0;
        end else begin
            state        <= state_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            hi1_q        <= hi1_d;
            lo_q         <= lo_d;
            retries_q    <= retries_d;
            req_ready    <= req_ready_d;
            resp_valid   <= resp_valid_d;
            resp_data    <= resp_data_d;
            resp_error   <= resp_error_d;
            resp_retries <= resp_retries_d;
            csr_cmd      <= csr_cmd_d;
            csr_addr     <= csr_addr_d;
            csr_wdata    <= csr_wdata_d;
        end
    end

    // Next state, datapath captures and next values of every registered output
    always_comb begin
        state_d        = state;
        sel_d          = sel_q;
        wdata_d        = wdata_q;
        hi1_d          = hi1_q;
        lo_d           = lo_q;
        retries_d      = retries_q;
        resp_data_d    = resp_data;
        resp_error_d   = resp_error;
        resp_retries_d = resp_retries;
        csr_cmd_d      = CSR_READ;
        csr_addr_d     = '0;
        csr_wdata_d    = '0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    sel_d     = req_sel;
                    wdata_d   = req_wdata;
                    retries_d = '0;
                    if (req_sel == SEL_INVALID) begin
                        state_d      = RESP;
                        resp_data_d  = '0;
                        resp_error_d = 1'b1;
                    end else if (req_write) begin
                        state_d = WR_LO;
                    end else begin
                        state_d = RD_HI1;
                    end
                end
            end
            RD_HI1: begin
                hi1_d   = csr_rdata;
                state_d = RD_LO;
            end
            RD_LO: begin
                lo_d    = csr_rdata;
                state_d = RD_HI2;
            end
            RD_HI2: begin
                if (csr_rdata == hi1_q) begin
                    resp_data_d  = {hi1_q, lo_q};
                    resp_error_d = 1'b0;
                    state_d      = RESP;
                end else if (retries_q < RETRY_LIMIT) begin
                    // High half moved: re-read low against the newer high value
                    retries_d = retries_q + RETRY_W'(1);
                    hi1_d     = csr_rdata;
                    state_d   = RD_LO;
                end else begin
                    resp_data_d  = {csr_rdata, lo_q};
                    resp_error_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WR_LO: begin
                state_d = WR_HI;
            end
            WR_HI: begin
                resp_data_d  = '0;
                resp_error_d = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_data_d    = '0;
                    resp_error_d   = 1'b0;
                    resp_retries_d = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Retry count is published once, on entry to RESP, and held there
        if (state_d == RESP && state != RESP) begin
            resp_retries_d = retries_d;
        end

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);

        // CSR port is a pure decode of the upcoming state and latched request
        unique case (state_d)
            RD_HI1, RD_HI2: csr_addr_d = hi_addr(sel_d);
            RD_LO:          csr_addr_d = lo_addr(sel_d);
            WR_LO: begin
                csr_cmd_d   = CSR_WRITE;
                csr_addr_d  = lo_addr(sel_d);
                csr_wdata_d = wdata_d[XLEN-1:0];
            end
            WR_HI: begin
                csr_cmd_d   = CSR_WRITE;
                csr_addr_d  = hi_addr(sel_d);
                csr_wdata_d = wdata_d[CW-1:XLEN];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_counter_reader.sv
// Testbench for csr_counter_reader: behavioural CSR counter model, table of
// read/write transactions with a response scoreboard, and hand-written
// sequences for response stall and mid-sequence reset.
module tb_csr_counter_reader;

    localparam logic [1:0]  CMD_READ  = 2'd0;
    localparam logic [1:0]  CMD_WRITE = 2'd1;
    localparam logic [11:0] LO_BASE   = 12'hC00;
    localparam logic [11:0] HI_BASE   = 12'hC80;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_sel;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_error;
    logic [1:0]  resp_retries;
    logic [1:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    logic        tick_en;
    logic        chaos_en;
    logic [63:0] ctr [3];
    logic [31:0] chaos_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  sel;
        logic [63:0] wdata;
        int          tick;
        logic        chaos;
        int          lat;
        logic [63:0] data;
        logic        err;
        logic [1:0]  ret;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic [1:0]  ret;
    } exp_t;

    exp_t sb_q[$];

    csr_counter_reader dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_sel      (req_sel),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_error   (resp_error),
        .resp_retries (resp_retries),
        .csr_cmd      (csr_cmd),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR counter model: writes land on the clock edge, time may tick,
    // chaos mode makes every high-half read return a fresh value.
    always @(posedge clk) begin
        if (!chaos_en) begin
            chaos_cnt <= 32'd1;
        end else if (csr_addr >= HI_BASE && csr_addr < HI_BASE + 12'd3) begin
            chaos_cnt <= chaos_cnt + 32'd1;
        end
        if (csr_cmd == CMD_WRITE) begin
            for (int i = 0; i < 3; i++) begin
                if (csr_addr == LO_BASE + 12'(i)) ctr[i][31:0]  <= csr_wdata;
                if (csr_addr == HI_BASE + 12'(i)) ctr[i][63:32] <= csr_wdata;
            end
        end else if (tick_en) begin
            ctr[1] <= ctr[1] + 64'd1;
        end
    end

    always_comb begin
        csr_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            if (csr_addr == LO_BASE + 12'(i)) csr_rdata = ctr[i][31:0];
            if (csr_addr == HI_BASE + 12'(i)) csr_rdata = chaos_en ? chaos_cnt : ctr[i][63:32];
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check64({tag, " req_ready"},    64'(req_ready),    64'd1);
        check64({tag, " resp_valid"},   64'(resp_valid),   64'd0);
        check64({tag, " resp_data"},    resp_data,         64'd0);
        check64({tag, " resp_error"},   64'(resp_error),   64'd0);
        check64({tag, " resp_retries"}, 64'(resp_retries), 64'd0);
        check64({tag, " csr_cmd"},      64'(csr_cmd),      64'(CMD_READ));
        check64({tag, " csr_addr"},     64'(csr_addr),     64'd0);
        check64({tag, " csr_wdata"},    64'(csr_wdata),    64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; called #1 after an edge with the DUT idle
    task automatic run_txn(input vec_t v, input string tag);
        int   n;
        exp_t e;
        check64({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_sel   = v.sel;
        req_wdata = v.wdata;
        chaos_en  = v.chaos;
        e.data = v.data;
        e.err  = v.err;
        e.ret  = v.ret;
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_sel   = 2'($urandom);
        req_wdata = {$urandom, $urandom};
        n = 1;
        tick_en = (v.tick > 0);
        while (!resp_valid && n < 40) begin
            if (v.sel != 2'd3 && (n == 1 || n == 2)) begin
                if (v.wr) begin
                    check64({tag, " wr cmd"},   64'(csr_cmd), 64'(CMD_WRITE));
                    check64({tag, " wr addr"},  64'(csr_addr),
                            64'((n == 1 ? LO_BASE : HI_BASE) + 12'(v.sel)));
                    check64({tag, " wr wdata"}, 64'(csr_wdata),
                            64'(n == 1 ? v.wdata[31:0] : v.wdata[63:32]));
                end else begin
                    check64({tag, " rd cmd"},   64'(csr_cmd), 64'(CMD_READ));
                    check64({tag, " rd addr"},  64'(csr_addr),
                            64'((n == 1 ? HI_BASE : LO_BASE) + 12'(v.sel)));
                end
            end
            step();
            n++;
            tick_en = (n <= v.tick);
        end
        tick_en = 1'b0;
        if (!resp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: resp_valid=0, expected 1 within 40 cycles", tag);
        end
        check64({tag, " latency"}, 64'(n), 64'(v.lat));
        e = sb_q.pop_front();
        check64({tag, " resp_data"},    resp_data,         e.data);
        check64({tag, " resp_error"},   64'(resp_error),   64'(e.err));
        check64({tag, " resp_retries"}, 64'(resp_retries), 64'(e.ret));
        check64({tag, " resp csr_cmd"}, 64'(csr_cmd),      64'(CMD_READ));
        check64({tag, " resp csr_addr"}, 64'(csr_addr),    64'd0);
        chaos_en = 1'b0;
        step();
        check64({tag, " post resp_valid"}, 64'(resp_valid), 64'd0);
        check64({tag, " post req_ready"},  64'(req_ready),  64'd1);
    endtask

    vec_t vecs[9];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 2'd0, 64'h00000002_00000010, 0, 1'b0, 3, 64'd0, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 2'd0, 64'd0, 0, 1'b0, 4, 64'h00000002_00000010, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 2'd2, 64'hAAAA5555_12345678, 0, 1'b0, 3, 64'd0, 1'b0, 2'd0};
        vecs[3] = '{1'b0, 2'd2, 64'd0, 0, 1'b0, 4, 64'hAAAA5555_12345678, 1'b0, 2'd0};
        vecs[4] = '{1'b0, 2'd3, 64'd0, 0, 1'b0, 1, 64'd0, 1'b1, 2'd0};
        vecs[5] = '{1'b1, 2'd3, 64'hDEADBEEF_CAFEF00D, 0, 1'b0, 1, 64'd0, 1'b1, 2'd0};
        vecs[6] = '{1'b1, 2'd1, 64'h00000001_FFFFFFFE, 0, 1'b0, 3, 64'd0, 1'b0, 2'd0};
        vecs[7] = '{1'b0, 2'd1, 64'd0, 2, 1'b0, 6, 64'h00000002_00000000, 1'b0, 2'd1};
        vecs[8] = '{1'b0, 2'd0, 64'd0, 0, 1'b1, 10, 64'h00000005_00000010, 1'b1, 2'd3};

        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_sel    = 2'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b1;
        tick_en    = 1'b0;
        chaos_en   = 1'b0;
        reset      = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("reset");
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_vals("after reset");

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Response held off for 5 cycles: outputs must stay put
        req_valid = 1'b1;
        req_write = 1'b0;
        req_sel   = 2'd0;
        step();
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        begin
            int n;
            n = 1;
            while (!resp_valid && n < 20) begin
                step();
                n++;
            end
            check64("stall latency", 64'(n), 64'd4);
        end
        for (int k = 0; k < 5; k++) begin
            check64("stall resp_valid",   64'(resp_valid),   64'd1);
            check64("stall resp_data",    resp_data,         64'h00000002_00000010);
            check64("stall resp_error",   64'(resp_error),   64'd0);
            check64("stall resp_retries", 64'(resp_retries), 64'd0);
            check64("stall req_ready",    64'(req_ready),    64'd0);
            step();
        end
        check64("stall still valid", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        step();
        check64("stall released resp_valid", 64'(resp_valid), 64'd0);
        check64("stall released req_ready",  64'(req_ready),  64'd1);

        // Reset asserted while in RD_LO
        req_valid = 1'b1;
        req_write = 1'b0;
        req_sel   = 2'd0;
        step();
        req_valid = 1'b0;
        step();
        check64("rdlo csr_addr", 64'(csr_addr), 64'(LO_BASE));
        reset = 1'b0;
        #1;
        check_reset_vals("rdlo reset");
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check64("rdlo no resp_valid", 64'(resp_valid), 64'd0);
            check64("rdlo no csr write",  64'(csr_cmd),    64'(CMD_READ));
            check64("rdlo req_ready",     64'(req_ready),  64'd1);
        end

        // Reset asserted while in WR_HI: high half must not be written
        req_valid = 1'b1;
        req_write = 1'b1;
        req_sel   = 2'd0;
        req_wdata = 64'h77777777_88888888;
        step();
        req_valid = 1'b0;
        check64("wrhi cycle1 cmd", 64'(csr_cmd), 64'(CMD_WRITE));
        step();
        check64("wrhi cycle2 addr", 64'(csr_addr), 64'(HI_BASE));
        reset = 1'b0;
        #1;
        check_reset_vals("wrhi reset");
        step();
        reset = 1'b1;
        step();
        check64("wrhi no resp_valid", 64'(resp_valid), 64'd0);
        rv = '{1'b0, 2'd0, 64'd0, 0, 1'b0, 4, 64'h00000002_88888888, 1'b0, 2'd0};
        run_txn(rv, "wrhi readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
